// File: rtl/prog_mem_loader_if.sv
// Byte-stream handshake into the loader plus its one-word-per-cycle program memory write port.
interface prog_mem_loader_if #(
  parameter int ADDRESS_WIDTH      = 8,
  parameter int PROGRAM_DATA_WIDTH = 17
);
  logic [7:0]                    byte_in;
  logic                          byte_valid;
  logic                          byte_ready;
  logic                          wr_en;
  logic [ADDRESS_WIDTH-1:0]      wr_addr;
  logic [PROGRAM_DATA_WIDTH-1:0] wr_data;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Assembles 3-byte MSB-first instruction words from a byte stream and writes them to program memory.
// Write strobe one cycle after the last byte of a word; byte_ready drops in the write cycle, so >= 4 cycles/word.
module prog_mem_loader #(
  parameter int ADDRESS_WIDTH      = 8,
  parameter int PROGRAM_DATA_WIDTH = 17,
  parameter int NUM_ADDRESSES      = 2**ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  prog_mem_loader_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDRESS_WIDTH:0]   words_loaded
);
  localparam int HI_W = PROGRAM_DATA_WIDTH - 16;
  localparam int CW   = ADDRESS_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, COUNT, B_HI, B_MID, B_LO, WRITE, DONE} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pointer;
  logic [CW-1:0]            remaining;
  logic [HI_W-1:0]          word_hi;
  logic [7:0]               word_mid;
  logic                     accept;

  assign accept = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      words_loaded   <= '0;
      pointer        <= '0;
      remaining      <= '0;
      word_hi        <= '0;
      word_mid       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state          <= COUNT;
          busy           <= 1'b1;
          err            <= 1'b0;
          words_loaded   <= '0;
          pointer        <= load_addr;
          bus.byte_ready <= 1'b1;
        end
        // A count byte of zero means a full-memory load.
        COUNT: if (accept) begin
          remaining <= (bus.byte_in == 8'd0) ? CW'(NUM_ADDRESSES) : CW'(bus.byte_in);
          state     <= B_HI;
        end
        B_HI: if (accept) begin
          if ((bus.byte_in >> HI_W) != 8'd0) begin
            err            <= 1'b1;
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
            state          <= IDLE;
          end else begin
            word_hi <= bus.byte_in[HI_W-1:0];
            state   <= B_MID;
          end
        end
        B_MID: if (accept) begin
          word_mid <= bus.byte_in;
          state    <= B_LO;
        end
        B_LO: if (accept) begin
          bus.wr_addr    <= pointer;
          bus.wr_data    <= {word_hi, word_mid, bus.byte_in};
          bus.wr_en      <= 1'b1;
          bus.byte_ready <= 1'b0;
          state          <= WRITE;
        end
        WRITE: begin
          bus.wr_en    <= 1'b0;
          pointer      <= pointer + ADDRESS_WIDTH'(1);
          words_loaded <= words_loaded + CW'(1);
          remaining    <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state          <= B_HI;
            bus.byte_ready <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised sessions against a queue-based model of the expected byte stream and memory writes.
module tb_prog_mem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] load_addr;
  logic       busy, done, err;
  logic [8:0] words_loaded;

  prog_mem_loader_if bus ();

  prog_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .load_addr(load_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  tx[$];
  logic [16:0] words_q[$];
  logic [7:0]  exp_addr[$];
  logic [16:0] exp_data[$];
  logic [7:0]  got_addr[$];
  logic [16:0] got_data[$];

  bit saw_done, saw_err, timed_out;
  int done_gap, ready_bad, busy_bad;

  // Reference: count byte, then each word as {0000000,w[16]}, w[15:8], w[7:0]; writes at consecutive wrapped addresses.
  task automatic model(input logic [7:0] la, input logic [7:0] cnt);
    tx.delete(); exp_addr.delete(); exp_data.delete();
    tx.push_back(cnt);
    for (int i = 0; i < words_q.size(); i++) begin
      tx.push_back({7'd0, words_q[i][16]});
      tx.push_back(words_q[i][15:8]);
      tx.push_back(words_q[i][7:0]);
      exp_addr.push_back(8'((int'(la) + i) % 256));
      exp_data.push_back(words_q[i]);
    end
  endtask

  task automatic run_session(input logic [7:0] la, input int drop_pct, input bit noise, input int budget);
    int cyc, last_wr;
    logic rdy;
    got_addr.delete(); got_data.delete();
    saw_done = 0; saw_err = 0; timed_out = 0;
    done_gap = -1; ready_bad = 0; busy_bad = 0; last_wr = -100; cyc = 0;
    @(negedge clk); start = 1'b1; load_addr = la;
    @(negedge clk); start = 1'b0; load_addr = 8'($urandom);
    while (!saw_done && !saw_err && !timed_out) begin
      if (bus.wr_en) begin
        got_addr.push_back(bus.wr_addr); got_data.push_back(bus.wr_data);
        if (bus.byte_ready) ready_bad++;
        last_wr = cyc;
      end
      if (done) begin saw_done = 1; done_gap = cyc - last_wr; if (busy) busy_bad++; end
      if (err) saw_err = 1;
      if (!saw_done && !saw_err) begin
        if (cyc >= budget) timed_out = 1;
        else begin
          bus.byte_valid = (tx.size() > 0) && (int'($urandom_range(99)) >= drop_pct);
          bus.byte_in    = bus.byte_valid ? tx[0] : 8'($urandom);
          start          = noise && ($urandom_range(3) == 0);
          rdy            = bus.byte_ready;
          @(posedge clk);
          if (bus.byte_valid && rdy) void'(tx.pop_front());
          @(negedge clk);
          cyc++;
        end
      end
    end
    bus.byte_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load_addr = '0; bus.byte_valid = 1'b0; bus.byte_in = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.byte_ready, bus.wr_en, busy, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {bus.byte_ready, bus.wr_en, busy, done, err});
    end
    tests++;
    if ({bus.wr_addr, bus.wr_data, words_loaded} !== 34'd0) begin
      fails++; $display("FAIL reset_values: got addr %h data %h wl %0d expected 0", bus.wr_addr, bus.wr_data, words_loaded);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: got busy %b ready %b expected 0 0", busy, bus.byte_ready);
    end
  endtask

  task automatic test_single_word();
    words_q.delete(); words_q.push_back(17'h09200);
    model(8'h00, 8'h01);
    run_session(8'h00, 0, 1'b0, 100);
    tests++;
    if (timed_out || got_addr.size() != 1) begin
      fails++; $display("FAIL single_count: got %0d writes (timeout %0b) expected 1", got_addr.size(), timed_out);
    end else begin
      tests++;
      if (got_addr[0] !== 8'h00 || got_data[0] !== 17'h09200) begin
        fails++; $display("FAIL single_write: got %h@%h expected 09200@00", got_data[0], got_addr[0]);
      end
    end
    tests++;
    if (!saw_done || done_gap != 1 || busy_bad != 0) begin
      fails++; $display("FAIL single_done: got done %0b gap %0d busybad %0d expected 1 1 0", saw_done, done_gap, busy_bad);
    end
    tests++;
    if (words_loaded !== 9'd1 || err !== 1'b0) begin
      fails++; $display("FAIL single_status: got wl %0d err %b expected 1 0", words_loaded, err);
    end
  endtask

  task automatic test_back_pressure();
    words_q.delete();
    words_q.push_back(17'h09200); words_q.push_back(17'h0b400);
    words_q.push_back(17'h0a088); words_q.push_back(17'h05000);
    model(8'h00, 8'h04);
    run_session(8'h00, 40, 1'b0, 400);
    tests++;
    if (timed_out || got_addr.size() != 4) begin
      fails++; $display("FAIL bp_count: got %0d writes (timeout %0b) expected 4", got_addr.size(), timed_out);
    end else
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          fails++; $display("FAIL bp_write%0d: got %h@%h expected %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    tests++;
    if (ready_bad != 0 || words_loaded !== 9'd4 || done_gap != 1) begin
      fails++; $display("FAIL bp_status: got readybad %0d wl %0d gap %0d expected 0 4 1", ready_bad, words_loaded, done_gap);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] la;
    words_q.delete();
    repeat (3) words_q.push_back(17'h1448f);
    model(8'hFE, 8'h03);
    run_session(8'hFE, 20, 1'b0, 200);
    tests++;
    if (timed_out || got_addr.size() != 3 || got_addr[0] !== 8'hFE || got_addr[1] !== 8'hFF ||
        got_addr[2] !== 8'h00 || got_data[2] !== 17'h1448f) begin
      fails++; $display("FAIL wrap3: got %0d writes, last addr %h expected 3 writes FE FF 00", got_addr.size(),
                        got_addr.size() > 0 ? got_addr[got_addr.size()-1] : 8'hxx);
    end
    la = 8'($urandom);
    words_q.delete();
    repeat (256) words_q.push_back(17'($urandom));
    model(la, 8'h00);
    run_session(la, 15, 1'b1, 4000);
    tests++;
    if (timed_out || got_addr.size() != 256 || got_addr != exp_addr || got_data != exp_data) begin
      fails++; $display("FAIL wrap256: got %0d writes (timeout %0b) expected 256 matching model", got_addr.size(), timed_out);
    end else begin
      tests++;
      if (got_addr[255] !== la - 8'd1) begin
        fails++; $display("FAIL wrap256_last: got %h expected %h", got_addr[255], la - 8'd1);
      end
    end
    tests++;
    if (words_loaded !== 9'd256 || !saw_done) begin
      fails++; $display("FAIL wrap256_status: got wl %0d done %0b expected 256 1", words_loaded, saw_done);
    end
  endtask

  task automatic test_format_error();
    tx.delete();
    tx.push_back(8'h02); tx.push_back(8'h03); tx.push_back(8'h12); tx.push_back(8'h34);
    run_session(8'h10, 0, 1'b0, 100);
    tests++;
    if (!saw_err || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      fails++; $display("FAIL fmt_err: got err %0b busy %b ready %b expected 1 0 0", saw_err, busy, bus.byte_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (got_addr.size() != 0 || saw_done || bus.wr_en !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL fmt_quiet: got %0d writes done %0b err %b expected 0 0 1", got_addr.size(), saw_done, err);
    end
    words_q.delete(); words_q.push_back(17'($urandom));
    model(8'h10, 8'h01);
    run_session(8'h10, 20, 1'b0, 100);
    tests++;
    if (saw_err || err !== 1'b0 || !saw_done || got_data.size() != 1 || got_data[0] !== exp_data[0]) begin
      fails++; $display("FAIL fmt_recover: got err %b done %0b writes %0d expected 0 1 1", err, saw_done, got_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    @(negedge clk); start = 1'b1; load_addr = 8'h40;
    @(negedge clk); start = 1'b0;
    bus.byte_valid = 1'b1; bus.byte_in = 8'h02;
    @(negedge clk); bus.byte_in = 8'h01;
    @(negedge clk); bus.byte_in = 8'hAB;
    @(negedge clk); if (bus.wr_en) wr_seen++; bus.byte_in = 8'hCD; reset = 1'b1;
    @(negedge clk); reset = 1'b0; bus.byte_valid = 1'b0;
    tests++;
    if ({bus.byte_ready, bus.wr_en, busy, done, err, bus.wr_addr, bus.wr_data, words_loaded} !== 39'd0) begin
      fails++; $display("FAIL midreset_state: got rdy %b wr %b busy %b done %b err %b addr %h data %h wl %0d expected all 0",
                        bus.byte_ready, bus.wr_en, busy, done, err, bus.wr_addr, bus.wr_data, words_loaded);
    end
    repeat (4) begin @(negedge clk); if (bus.wr_en) wr_seen++; end
    tests++;
    if (wr_seen != 0) begin
      fails++; $display("FAIL midreset_nowrite: got %0d writes expected 0", wr_seen);
    end
    words_q.delete(); words_q.push_back(17'($urandom)); words_q.push_back(17'($urandom));
    model(8'h40, 8'h02);
    run_session(8'h40, 25, 1'b0, 200);
    tests++;
    if (timed_out || got_addr != exp_addr || got_data != exp_data || words_loaded !== 9'd2) begin
      fails++; $display("FAIL midreset_fresh: got %0d writes wl %0d expected 2 matching model", got_addr.size(), words_loaded);
    end
  endtask

  task automatic test_random_sessions();
    logic [7:0] la;
    int n;
    for (int s = 0; s < 6; s++) begin
      la = 8'($urandom);
      n  = $urandom_range(1, 9);
      words_q.delete();
      repeat (n) words_q.push_back(17'($urandom));
      model(la, 8'(n));
      run_session(la, 35, 1'b1, 500);
      tests++;
      if (timed_out || got_addr != exp_addr || got_data != exp_data || words_loaded !== 9'(n) ||
          done_gap != 1 || ready_bad != 0 || busy_bad != 0) begin
        fails++; $display("FAIL rand%0d: got %0d writes wl %0d gap %0d expected %0d writes matching model gap 1",
                          s, got_addr.size(), words_loaded, done_gap, n);
      end
      // start presented while done is high must not open a session.
      start = 1'b1; load_addr = 8'($urandom);
      @(negedge clk); start = 1'b0;
      tests++;
      if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
        fails++; $display("FAIL rand%0d_start_in_done: got busy %b ready %b expected 0 0", s, busy, bus.byte_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_pressure();
    test_wrap();
    test_format_error();
    test_reset_mid();
    test_random_sessions();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
